bus_master_8086: RTL and testbench

BUS_MASTER_8086 -- requirements
Module: bus_master_8086

---
 rtl/bus_master_8086.sv | 194 +++++++++++++++++++
 tb/tb_bus_master_8086.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_master_8086.sv
// 8086 minimum-mode bus master.
// One request in, one T1..T4 bus cycle out (two cycles for an odd-address word),
// with READY-driven wait states, a 15-wait timeout and a single completion pulse.
module bus_master_8086 (
    input  logic        clk,
    input  logic        RESET,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_mem,
    input  logic        req_word,
    input  logic [19:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic [19:0] LAD_OUT,
    output logic        LAD_OE,
    input  logic [15:0] LAD_IN,
    output logic        ALE,
    output logic        BHE_N,
    output logic        M_IO,
    output logic        RD_N,
    output logic        WR_N,
    output logic        DEN_N,
    output logic        DT_R,
    input  logic        READY
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_T1   = 3'd1;
    localparam logic [2:0] S_T2   = 3'd2;
    localparam logic [2:0] S_T3   = 3'd3;
    localparam logic [2:0] S_TW   = 3'd4;
    localparam logic [2:0] S_T4   = 3'd5;

    logic [2:0]  state;
    logic [3:0]  wait_cnt;
    logic [19:0] cyc_addr;   // address of the bus cycle in flight
    logic        cyc_word;   // bus cycle uses both lanes
    logic        second;     // bus cycle is the second half of a split word
    logic        pend;       // a second half follows this cycle's T4
    logic        r_write;
    logic        r_mem;
    logic [15:0] r_wdata;
    logic [7:0]  byte1;      // byte read by the first half of a split word

    logic        accept;
    logic        split_next;
    logic        start_t1;
    logic [19:0] t1_addr;
    logic        t1_mem;
    logic        t1_write;
    logic        t1_word;
    logic [7:0]  wr_byte;
    logic [15:0] wr_lanes;
    logic [7:0]  rd_byte;
    logic [15:0] rd_result;

    // Ready for a new request when idle, or in the last T4 of a transfer.
    always_comb begin
        req_ready = (state == S_IDLE) || ((state == S_T4) && !pend);
    end

    assign accept     = req_valid && req_ready;
    assign split_next = (state == S_T4) && pend;
    assign start_t1   = accept || split_next;

    // Parameters of the next T1: either the second half of a split word or a fresh request.
    always_comb begin
        if (split_next) begin
            t1_addr  = cyc_addr + 20'd1;
            t1_mem   = r_mem;
            t1_write = r_write;
            t1_word  = 1'b0;
        end else begin
            t1_addr  = req_addr;
            t1_mem   = req_mem;
            t1_write = req_write;
            t1_word  = req_word && !req_addr[0];
        end
    end

    // Lane steering: byte cycles put the byte on both lanes; the odd/even lane
    // is the one the responder picks via A0/BHE_N. Reads pick the lane by A0.
    always_comb begin
        wr_byte  = second ? r_wdata[15:8] : r_wdata[7:0];
        wr_lanes = cyc_word ? r_wdata : {wr_byte, wr_byte};
        rd_byte  = cyc_addr[0] ? LAD_IN[15:8] : LAD_IN[7:0];
        if (r_write)
            rd_result = 16'h0000;
        else if (cyc_word)
            rd_result = LAD_IN;
        else if (second)
            rd_result = {rd_byte, byte1};
        else
            rd_result = {8'h00, rd_byte};
    end

    // Bus-cycle FSM with all bus and response outputs registered.
    always_ff @(posedge clk) begin
        if (RESET) begin
            state     <= S_IDLE;
            wait_cnt  <= 4'd0;
            cyc_addr  <= 20'd0;
            cyc_word  <= 1'b0;
            second    <= 1'b0;
            pend      <= 1'b0;
            r_write   <= 1'b0;
            r_mem     <= 1'b0;
            r_wdata   <= 16'd0;
            byte1     <= 8'd0;
            ALE       <= 1'b0;
            RD_N      <= 1'b1;
            WR_N      <= 1'b1;
            DEN_N     <= 1'b1;
            BHE_N     <= 1'b1;
            DT_R      <= 1'b0;
            M_IO      <= 1'b0;
            LAD_OE    <= 1'b0;
            LAD_OUT   <= 20'd0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= 16'd0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            if (start_t1) begin
                state    <= S_T1;
                wait_cnt <= 4'd0;
                ALE      <= 1'b1;
                LAD_OE   <= 1'b1;
                LAD_OUT  <= t1_mem ? t1_addr : {4'h0, t1_addr[15:0]};
                M_IO     <= t1_mem;
                DT_R     <= t1_write;
                BHE_N    <= !(t1_word || t1_addr[0]);
                cyc_addr <= t1_addr;
                cyc_word <= t1_word;
                if (accept) begin
                    r_write <= req_write;
                    r_mem   <= req_mem;
                    r_wdata <= req_wdata;
                    pend    <= req_word && req_addr[0];
                    second  <= 1'b0;
                end else begin
                    pend    <= 1'b0;
                    second  <= 1'b1;
                end
            end else begin
                case (state)
                    S_T1: begin
                        state <= S_T2;
                        ALE   <= 1'b0;
                        DEN_N <= 1'b0;
                        if (r_write) begin
                            WR_N    <= 1'b0;
                            LAD_OUT <= {4'h0, wr_lanes};
                        end else begin
                            RD_N   <= 1'b0;
                            LAD_OE <= 1'b0;
                        end
                    end
                    S_T2: state <= S_T3;
                    S_T3, S_TW: begin
                        if (READY || wait_cnt == 4'hF) begin
                            state  <= S_T4;
                            RD_N   <= 1'b1;
                            WR_N   <= 1'b1;
                            DEN_N  <= 1'b1;
                            LAD_OE <= 1'b0;
                            if (!READY) begin
                                // Timeout ends the transfer, dropping any second half.
                                pend      <= 1'b0;
                                rsp_valid <= 1'b1;
                                rsp_err   <= 1'b1;
                                rsp_rdata <= 16'hFFFF;
                            end else if (pend) begin
                                byte1 <= rd_byte;
                            end else begin
                                rsp_valid <= 1'b1;
                                rsp_rdata <= rd_result;
                            end
                        end else begin
                            state    <= S_TW;
                            wait_cnt <= wait_cnt + 4'd1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bus_master_8086.sv
// Self-checking bench for bus_master_8086: a vector table of single transfers
// plus hand-written sequences for back-to-back requests and mid-cycle reset.
module tb_bus_master_8086;

    logic        clk = 1'b0;
    logic        RESET = 1'b1;
    logic        req_valid = 1'b0, req_ready;
    logic        req_write = 1'b0, req_mem = 1'b0, req_word = 1'b0;
    logic [19:0] req_addr = 20'd0;
    logic [15:0] req_wdata = 16'd0;
    logic        rsp_valid, rsp_err;
    logic [15:0] rsp_rdata;
    logic [19:0] LAD_OUT;
    logic        LAD_OE;
    logic [15:0] LAD_IN = 16'd0;
    logic        ALE, BHE_N, M_IO, RD_N, WR_N, DEN_N, DT_R;
    logic        READY = 1'b0;

    bus_master_8086 dut (
        .clk(clk), .RESET(RESET),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_mem(req_mem), .req_word(req_word),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .LAD_OUT(LAD_OUT), .LAD_OE(LAD_OE), .LAD_IN(LAD_IN),
        .ALE(ALE), .BHE_N(BHE_N), .M_IO(M_IO), .RD_N(RD_N), .WR_N(WR_N),
        .DEN_N(DEN_N), .DT_R(DT_R), .READY(READY)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        write, mem, word;
        logic [19:0] addr;
        logic [15:0] wdata;
        int          dly;
        logic [15:0] rdata;
        logic        err;
        int          len, nale, strb;
        logic        bhe1;
        logic [19:0] a1;
        logic        bhe2;
        logic [19:0] a2;
        logic [15:0] m1, e1, m2, e2;
    } vec_t;

    typedef struct {
        logic        rd;
        logic [15:0] rdata;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    vec_t        vt[11];
    int          n_pass = 0, n_total = 0;
    int          dly = 0, k = 0;
    int          n_ale = 0, n_wr = 0, n_rd = 0, n_rsp = 0;
    logic [19:0] lat, a1, a2;
    logic        bhe1, bhe2, mio1;
    logic [15:0] wr_first, wr_last;

    // Responder memory contents: a fixed hash of the byte address.
    function automatic logic [7:0] mb(input logic [19:0] a);
        return a[7:0] ^ {a[11:8], a[15:12]} ^ {4'h3, a[19:16]};
    endfunction

    function automatic vec_t mk(
        input logic w, input logic m, input logic wd, input logic [19:0] ad,
        input logic [15:0] wdat, input int dl, input logic [15:0] rd, input logic er,
        input int ln, input int na, input int st,
        input logic b1, input logic [19:0] x1, input logic b2, input logic [19:0] x2,
        input logic [15:0] mk1, input logic [15:0] ek1,
        input logic [15:0] mk2, input logic [15:0] ek2);
        vec_t v;
        v.write = w; v.mem = m; v.word = wd; v.addr = ad; v.wdata = wdat; v.dly = dl;
        v.rdata = rd; v.err = er; v.len = ln; v.nale = na; v.strb = st;
        v.bhe1 = b1; v.a1 = x1; v.bhe2 = b2; v.a2 = x2;
        v.m1 = mk1; v.e1 = ek1; v.m2 = mk2; v.e2 = ek2;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endtask

    task automatic clear_mon();
        n_ale = 0; n_wr = 0; n_rd = 0; n_rsp = 0;
    endtask

    // Responder and monitor: latch address at ALE, drive LAD_IN, pace READY,
    // record strobes, and check each completion against the scoreboard.
    always @(negedge clk) begin
        if (ALE === 1'b1) begin
            if (n_ale == 0) begin a1 = LAD_OUT; bhe1 = BHE_N; mio1 = M_IO; end
            a2 = LAD_OUT; bhe2 = BHE_N; n_ale++;
            lat = LAD_OUT;
            LAD_IN = {mb({lat[19:1], 1'b1}), mb({lat[19:1], 1'b0})};
            k = 0;
        end else begin
            k++;
        end
        READY = (k >= 2 + dly);
        if (WR_N === 1'b0) begin
            if (n_wr == 0) wr_first = LAD_OUT[15:0];
            wr_last = LAD_OUT[15:0];
            n_wr++;
        end
        if (RD_N === 1'b0) n_rd++;
        if (rsp_valid === 1'b1) begin
            n_rsp++;
            chk("scoreboard has entry for rsp", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                if (mon_e.rd) chk("rsp_rdata", 32'(rsp_rdata), 32'(mon_e.rdata));
                chk("rsp_err", 32'(rsp_err), 32'(mon_e.err));
            end
        end
    end

    task automatic run_vec(input int i, input vec_t v);
        int n;
        clear_mon();
        dly = v.dly;
        req_valid = 1'b1; req_write = v.write; req_mem = v.mem; req_word = v.word;
        req_addr = v.addr; req_wdata = v.wdata;
        exp_q.push_back('{!v.write, v.rdata, v.err});
        n = 0;
        while (req_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        chk($sformatf("v%0d accepted", i), 32'(n < 50), 1);
        @(negedge clk);
        req_valid = 1'b0;
        n = 1;
        while (rsp_valid !== 1'b1 && n < 60) begin @(negedge clk); n++; end
        chk($sformatf("v%0d clocks to rsp", i), n, v.len);
        chk($sformatf("v%0d ALE count", i), n_ale, v.nale);
        chk($sformatf("v%0d strobe clocks", i), v.write ? n_wr : n_rd, v.strb);
        chk($sformatf("v%0d T1 BHE_N", i), 32'(bhe1), 32'(v.bhe1));
        chk($sformatf("v%0d T1 addr", i), 32'(a1), 32'(v.a1));
        chk($sformatf("v%0d last T1 BHE_N", i), 32'(bhe2), 32'(v.bhe2));
        chk($sformatf("v%0d last T1 addr", i), 32'(a2), 32'(v.a2));
        chk($sformatf("v%0d M_IO", i), 32'(mio1), 32'(v.mem));
        if (v.write) begin
            chk($sformatf("v%0d first write lane", i), 32'(wr_first & v.m1), 32'(v.e1));
            chk($sformatf("v%0d last write lane", i), 32'(wr_last & v.m2), 32'(v.e2));
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        logic [11:0] ale_m, rsp_m;

        //       wr mem wd addr      wdata    dly rdata                        err len nale strb bhe1 a1        bhe2 a2        m1        e1        m2        e2
        vt[0]  = mk(0, 1, 1, 20'h12344, 16'h0000, 0, {mb(20'h12345), mb(20'h12344)}, 0, 4,  1, 2,  0, 20'h12344, 0, 20'h12344, 16'h0,    16'h0,    16'h0,    16'h0);
        vt[1]  = mk(1, 0, 0, 20'h00031, 16'h00A5, 0, 16'h0000,                     0, 4,  1, 2,  0, 20'h00031, 0, 20'h00031, 16'hFF00, 16'hA500, 16'hFF00, 16'hA500);
        vt[2]  = mk(0, 1, 1, 20'hFFFFF, 16'h0000, 0, {mb(20'h00000), mb(20'hFFFFF)}, 0, 8,  2, 4,  0, 20'hFFFFF, 1, 20'h00000, 16'h0,    16'h0,    16'h0,    16'h0);
        vt[3]  = mk(0, 1, 0, 20'h0ABC6, 16'h0000, 3, {8'h00, mb(20'h0ABC6)},       0, 7,  1, 5,  1, 20'h0ABC6, 1, 20'h0ABC6, 16'h0,    16'h0,    16'h0,    16'h0);
        vt[4]  = mk(0, 1, 1, 20'h4567A, 16'h0000, 99, 16'hFFFF,                    1, 19, 1, 17, 0, 20'h4567A, 0, 20'h4567A, 16'h0,    16'h0,    16'h0,    16'h0);
        vt[5]  = mk(1, 1, 1, 20'h54320, 16'hBEEF, 0, 16'h0000,                     0, 4,  1, 2,  0, 20'h54320, 0, 20'h54320, 16'hFFFF, 16'hBEEF, 16'hFFFF, 16'hBEEF);
        vt[6]  = mk(1, 1, 1, 20'h1FFFF, 16'h1234, 1, 16'h0000,                     0, 10, 2, 6,  0, 20'h1FFFF, 1, 20'h20000, 16'hFF00, 16'h3400, 16'h00FF, 16'h0012);
        vt[7]  = mk(0, 1, 1, 20'h33335, 16'h0000, 99, 16'hFFFF,                    1, 19, 1, 17, 0, 20'h33335, 0, 20'h33335, 16'h0,    16'h0,    16'h0,    16'h0);
        vt[8]  = mk(0, 0, 0, 20'hF0FF3, 16'h0000, 0, {8'h00, mb(20'h00FF3)},       0, 4,  1, 2,  0, 20'h00FF3, 0, 20'h00FF3, 16'h0,    16'h0,    16'h0,    16'h0);
        vt[9]  = mk(1, 0, 1, 20'h0FFFF, 16'h5AC3, 0, 16'h0000,                     0, 8,  2, 4,  0, 20'h0FFFF, 1, 20'h00000, 16'hFF00, 16'hC300, 16'h00FF, 16'h005A);
        vt[10] = mk(1, 1, 0, 20'h80002, 16'h77C8, 2, 16'h0000,                     0, 6,  1, 4,  1, 20'h80002, 1, 20'h80002, 16'h00FF, 16'h00C8, 16'h00FF, 16'h00C8);

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset control outputs",
            32'({ALE, RD_N, WR_N, DEN_N, BHE_N, DT_R, M_IO, LAD_OE, rsp_valid, rsp_err, req_ready}),
            32'(11'b0_1_1_1_1_0_0_0_0_0_1));
        chk("reset LAD_OUT", 32'(LAD_OUT), 0);
        chk("reset rsp_rdata", 32'(rsp_rdata), 0);
        RESET = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 11; i++) run_vec(i, vt[i]);

        // Back-to-back writes with req_valid held: T4 then T1, no IDLE.
        @(negedge clk);
        dly = 0; clear_mon(); ale_m = '0; rsp_m = '0;
        req_valid = 1'b1; req_write = 1'b1; req_mem = 1'b1; req_word = 1'b1;
        req_addr = 20'h00100; req_wdata = 16'h1111;
        exp_q.push_back('{1'b0, 16'h0000, 1'b0});
        exp_q.push_back('{1'b0, 16'h0000, 1'b0});
        for (c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 1) begin req_addr = 20'h00200; req_wdata = 16'h2222; end
            if (c == 4) chk("b2b req_ready in T4", 32'(req_ready), 1);
            if (c == 5) req_valid = 1'b0;
            ale_m[c-1] = (ALE === 1'b1);
            rsp_m[c-1] = (rsp_valid === 1'b1);
        end
        chk("b2b ALE clocks", 32'(ale_m), 32'(12'b0000_0001_0001));
        chk("b2b rsp clocks", 32'(rsp_m), 32'(12'b0000_1000_1000));
        chk("b2b addr 1", 32'(a1), 32'h00100);
        chk("b2b addr 2", 32'(a2), 32'h00200);
        chk("b2b data 1", 32'(wr_first), 32'h1111);
        chk("b2b data 2", 32'(wr_last), 32'h2222);

        // Reset during TW of a write: strobes drop, no response, ready after reset.
        dly = 99;
        req_valid = 1'b1; req_write = 1'b1; req_mem = 1'b1; req_word = 1'b1;
        req_addr = 20'h00400; req_wdata = 16'hABCD;
        for (c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 1) req_valid = 1'b0;
        end
        chk("rst-wr WR_N low in TW", 32'(WR_N), 0);
        RESET = 1'b1;
        @(negedge clk);
        chk("rst-wr WR_N", 32'(WR_N), 1);
        chk("rst-wr DEN_N", 32'(DEN_N), 1);
        chk("rst-wr rsp_valid", 32'(rsp_valid), 0);
        RESET = 1'b0;
        @(negedge clk);
        chk("rst-wr req_ready after reset", 32'(req_ready), 1);
        clear_mon();
        repeat (20) @(negedge clk);
        chk("rst-wr no rsp", n_rsp, 0);
        chk("rst-wr no bus cycle", n_ale, 0);

        // Reset during the first half of a split word: second half is dropped.
        req_valid = 1'b1; req_write = 1'b0; req_mem = 1'b1; req_word = 1'b1;
        req_addr = 20'h00501;
        for (c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 1) req_valid = 1'b0;
        end
        chk("rst-split RD_N low in TW", 32'(RD_N), 0);
        RESET = 1'b1;
        @(negedge clk);
        RESET = 1'b0;
        clear_mon();
        repeat (25) @(negedge clk);
        chk("rst-split no rsp", n_rsp, 0);
        chk("rst-split no second half", n_ale, 0);

        chk("scoreboard drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
